// File: rtl/rvr32_mem_arb_rr.sv
// Registered round-robin arbiter: four requesters share one 32-bit memory port.
// Define RVR32_ARB_TIMEOUT_EN to abort transactions that wait too long for mem_ready.
module rvr32_mem_arb_rr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [3:0]  wstrb0,
  input  logic        valid1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [3:0]  wstrb1,
  input  logic        valid2,
  input  logic [31:0] addr2,
  input  logic [31:0] wdata2,
  input  logic [3:0]  wstrb2,
  input  logic        valid3,
  input  logic [31:0] addr3,
  input  logic [31:0] wdata3,
  input  logic [3:0]  wstrb3,
  output logic        ready0,
  output logic        ready1,
  output logic        ready2,
  output logic        ready3,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant_id,
  output logic        busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  if (CNT_W < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
    $error("rvr32_mem_arb_rr: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  valid_vec;
  logic        pick_found;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic        timeout_hit;
  logic        complete;
  logic [3:0]  ready_vec;

  assign valid_vec = {valid3, valid2, valid1, valid0};

  // Search starts just past the last owner, so that owner has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + i[1:0];
      if (!pick_found && valid_vec[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef RVR32_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == BUSY) && !mem_ready &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && pick_found) begin
      cnt_d = '0;
    end else if (state_q == BUSY && !mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete = (state_q == BUSY) && (mem_ready || timeout_hit);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (complete) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Memory-side request follows the owner's live inputs; zeroed while idle.
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    if (state_q == BUSY) begin
      case (grant_q)
        2'd0: begin mem_addr = addr0; mem_wdata = wdata0; mem_wstrb = wstrb0; end
        2'd1: begin mem_addr = addr1; mem_wdata = wdata1; mem_wstrb = wstrb1; end
        2'd2: begin mem_addr = addr2; mem_wdata = wdata2; mem_wstrb = wstrb2; end
        default: begin mem_addr = addr3; mem_wdata = wdata3; mem_wstrb = wstrb3; end
      endcase
    end
  end

  assign ready_vec = complete ? (4'b0001 << grant_q) : 4'b0000;
  assign ready0    = ready_vec[0];
  assign ready1    = ready_vec[1];
  assign ready2    = ready_vec[2];
  assign ready3    = ready_vec[3];
  assign err       = timeout_hit;
  assign rdata     = timeout_hit ? 32'h0 : mem_rdata;
  assign mem_valid = (state_q == BUSY);
  assign busy      = (state_q == BUSY);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_rvr32_mem_arb_rr.sv
// Bench for rvr32_mem_arb_rr: directed scenarios with literal expectations,
// then randomized traffic checked against a transaction-level arbiter model.
module tb_rvr32_mem_arb_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        v [4];
  logic [31:0] a [4];
  logic [31:0] wd [4];
  logic [3:0]  ws [4];
  logic [3:0]  rdy;
  logic [31:0] rdata;
  logic        err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  grant_id;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  // model state
  bit m_busy;
  int m_owner;
  int m_last;
  bit pend [4];

  always #5 clk = ~clk;

  rvr32_mem_arb_rr dut (
    .clk(clk), .rst(rst),
    .valid0(v[0]), .addr0(a[0]), .wdata0(wd[0]), .wstrb0(ws[0]),
    .valid1(v[1]), .addr1(a[1]), .wdata1(wd[1]), .wstrb1(ws[1]),
    .valid2(v[2]), .addr2(a[2]), .wdata2(wd[2]), .wstrb2(ws[2]),
    .valid3(v[3]), .addr3(a[3]), .wdata3(wd[3]), .wstrb3(ws[3]),
    .ready0(rdy[0]), .ready1(rdy[1]), .ready2(rdy[2]), .ready3(rdy[3]),
    .rdata(rdata), .err(err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < 4; n++) begin
      v[n] = 1'b0; a[n] = 32'h0; wd[n] = 32'h0; ws[n] = 4'h0;
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_grant;
    logic [31:0] exp_addr;

    // ---- reset state, single requester on port 2
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_err", err, 0);
    v[2] = 1'b1; a[2] = 32'h100;
    #1 chk("p2_idle_valid", mem_valid, 0);
    @(negedge clk); #1;
    chk("p2_mem_valid", mem_valid, 1);
    chk("p2_mem_addr", mem_addr, 32'h100);
    chk("p2_grant", grant_id, 2);
    @(negedge clk); #1;
    chk("p2_wait_ready", rdy, 0);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("p2_ready", rdy, 4'b0100);
    chk("p2_rdata", rdata, 32'h1234_5678);
    @(negedge clk);
    mem_ready = 1'b0; v[2] = 1'b0;
    #1;
    chk("p2_after_busy", busy, 0);
    chk("p2_after_ready", rdy, 0);
    chk("p2_after_addr", mem_addr, 0);

    // ---- fairness: all four held, mem_ready always high
    do_reset();
    for (int n = 0; n < 4; n++) begin
      v[n] = 1'b1; a[n] = 32'h1000 + 32'(n) * 32'h10;
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rr_mem_valid", mem_valid, 32'(k % 2));
      if (k % 2 == 1) begin
        exp_grant = (k / 2) % 4;
        chk("rr_grant", grant_id, 32'(exp_grant));
        chk("rr_ready", rdy, 32'(4'b0001 << exp_grant));
        chk("rr_addr", mem_addr, 32'h1000 + 32'(exp_grant) * 32'h10);
      end else begin
        chk("rr_idle_ready", rdy, 0);
      end
      @(negedge clk);
    end

    // ---- owner 1 holds through a late request on port 3; write path
    do_reset();
    v[1] = 1'b1; a[1] = 32'h1111_0000; wd[1] = 32'hA5A5_A5A5; ws[1] = 4'b0011;
    @(negedge clk); #1;
    chk("w1_grant", grant_id, 1);
    chk("w1_wstrb", mem_wstrb, 4'b0011);
    chk("w1_wdata", mem_wdata, 32'hA5A5_A5A5);
    v[3] = 1'b1; a[3] = 32'h3333_0000;
    @(negedge clk); #1;
    chk("w1_hold_addr", mem_addr, 32'h1111_0000);
    chk("w1_hold_grant", grant_id, 1);
    mem_ready = 1'b1;
    #1;
    chk("w1_ready", rdy, 4'b0010);
    @(negedge clk);
    mem_ready = 1'b0; v[1] = 1'b0;
    #1;
    chk("w1_idle_wstrb", mem_wstrb, 0);
    chk("w1_idle_wdata", mem_wdata, 0);
    chk("w1_idle_valid", mem_valid, 0);
    @(negedge clk); #1;
    chk("w3_grant", grant_id, 3);
    chk("w3_addr", mem_addr, 32'h3333_0000);

    // ---- reset while port 2 owns the bus
    do_reset();
    v[2] = 1'b1; a[2] = 32'h200;
    @(negedge clk); #1;
    chk("r2_grant", grant_id, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; v[0] = 1'b1; a[0] = 32'h40;
    #1;
    chk("r2_mem_valid", mem_valid, 0);
    chk("r2_no_ready", rdy, 0);
    chk("r2_grant_rst", grant_id, 0);
    @(negedge clk); #1;
    chk("r2_first_grant", grant_id, 0);
    chk("r2_first_addr", mem_addr, 32'h40);

    // ---- long stall without mem_ready
    do_reset();
    v[0] = 1'b1; a[0] = 32'h80; mem_rdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk); #1;
`ifdef RVR32_ARB_TIMEOUT_EN
      if (k == 255) begin
        chk("to_ready", rdy, 4'b0001);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 0);
        break;
      end
`endif
      chk("stall_mem_valid", mem_valid, 1);
      chk("stall_err", err, 0);
      chk("stall_ready", rdy, 0);
    end

    // ---- randomized traffic against the model
    do_reset();
    m_busy = 1'b0; m_last = 3; m_owner = 0;
    for (int n = 0; n < 4; n++) pend[n] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      for (int n = 0; n < 4; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1'b1;
          a[n] = $urandom; wd[n] = $urandom; ws[n] = 4'($urandom_range(0, 15));
        end
        v[n] = pend[n];
      end
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      chk("rnd_busy", busy, 32'(m_busy));
      chk("rnd_mem_valid", mem_valid, 32'(m_busy));
      chk("rnd_ready", rdy, (m_busy && mem_ready) ? 32'(4'b0001 << m_owner) : 32'h0);
      chk("rnd_rdata", rdata, mem_rdata);
      chk("rnd_err", err, 0);
      exp_addr = m_busy ? a[m_owner] : 32'h0;
      chk("rnd_addr", mem_addr, exp_addr);
      chk("rnd_wdata", mem_wdata, m_busy ? wd[m_owner] : 32'h0);
      chk("rnd_wstrb", mem_wstrb, m_busy ? 32'(ws[m_owner]) : 32'h0);
      if (m_busy) chk("rnd_grant", grant_id, 32'(m_owner));
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_last = 3;
      end else if (m_busy) begin
        if (mem_ready) begin
          m_busy = 1'b0; m_last = m_owner; pend[m_owner] = 1'b0;
        end
      end else begin
        for (int i = 1; i <= 4; i++) begin
          if (v[(m_last + i) % 4]) begin
            m_owner = (m_last + i) % 4; m_busy = 1'b1;
            break;
          end
        end
      end
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
